// File: rtl/dfi_init_seq.sv
// DDR3 power-up sequencer: DRAM reset, CKE bring-up, MR2/MR3/MR1/MR0, ZQCL, then init_done.
// Drives the init-side DFI command fields; one run per reset.
module dfi_init_seq #(
  parameter int ADDR_WIDTH = 14,
  parameter int BANK_WIDTH = 3,
  parameter int CNT_W      = 20,
  parameter int T_RESET    = 100000,
  parameter int T_CKE      = 250000,
  parameter int T_XPR      = 64,
  parameter int T_MRD      = 4,
  parameter int T_MOD      = 12,
  parameter int T_ZQINIT   = 512,
  parameter logic [ADDR_WIDTH-1:0] MR0 = '0,
  parameter logic [ADDR_WIDTH-1:0] MR1 = '0,
  parameter logic [ADDR_WIDTH-1:0] MR2 = '0,
  parameter logic [ADDR_WIDTH-1:0] MR3 = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] dfi_address,
  output logic [BANK_WIDTH-1:0] dfi_bank,
  output logic                  dfi_ras_n,
  output logic                  dfi_cas_n,
  output logic                  dfi_we_n,
  output logic                  dfi_cs_n,
  output logic                  dfi_cke,
  output logic                  dfi_odt,
  output logic                  dfi_reset_n,
  output logic                  dfi_dram_clk_disable,
  output logic                  busy,
  output logic                  init_done,
  output logic [3:0]            dbg_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RST_HOLD = 4'd1;
  localparam logic [3:0] S_CKE_WAIT = 4'd2;
  localparam logic [3:0] S_XPR      = 4'd3;
  localparam logic [3:0] S_MR2      = 4'd4;
  localparam logic [3:0] S_MR3      = 4'd5;
  localparam logic [3:0] S_MR1      = 4'd6;
  localparam logic [3:0] S_MR0      = 4'd7;
  localparam logic [3:0] S_ZQCL     = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  // Counter preloads: a state with wait T loads T-1 and leaves when it reads 0.
  localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE - 1);
  localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD   = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LD_ZQ    = CNT_W'(T_ZQINIT - 1);

  localparam logic [ADDR_WIDTH-1:0] ZQ_ADDR = ADDR_WIDTH'(11'h400);

  logic [3:0]            state;
  logic [3:0]            next_state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      load_val;
  logic                  entering;

  logic [ADDR_WIDTH-1:0] address_d;
  logic [BANK_WIDTH-1:0] bank_d;
  logic                  ras_n_d;
  logic                  cas_n_d;
  logic                  we_n_d;
  logic                  cke_d;
  logic                  reset_n_d;
  logic                  clk_disable_d;
  logic                  busy_d;
  logic                  done_d;

  assign dbg_state = state;

  always_comb begin
    next_state = state;
    load_val   = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_RST_HOLD;
          load_val   = LD_RESET;
        end
      end
      S_RST_HOLD: if (cnt == '0) begin next_state = S_CKE_WAIT; load_val = LD_CKE; end
      S_CKE_WAIT: if (cnt == '0) begin next_state = S_XPR;      load_val = LD_XPR; end
      S_XPR:      if (cnt == '0) begin next_state = S_MR2;      load_val = LD_MRD; end
      S_MR2:      if (cnt == '0) begin next_state = S_MR3;      load_val = LD_MRD; end
      S_MR3:      if (cnt == '0) begin next_state = S_MR1;      load_val = LD_MRD; end
      S_MR1:      if (cnt == '0) begin next_state = S_MR0;      load_val = LD_MOD; end
      S_MR0:      if (cnt == '0) begin next_state = S_ZQCL;     load_val = LD_ZQ;  end
      S_ZQCL:     if (cnt == '0) begin next_state = S_DONE;     load_val = '0;     end
      default:    next_state = state;
    endcase
  end

  assign entering = (next_state != state);

  always_comb begin
    if (entering) begin
      cnt_d = load_val;
    end else if (cnt != '0) begin
      cnt_d = cnt - CNT_W'(1);
    end else begin
      cnt_d = cnt;
    end
  end

  // Outputs are decoded from the state being entered so they line up with the transition edge.
  always_comb begin
    address_d     = '0;
    bank_d        = '0;
    ras_n_d       = 1'b1;
    cas_n_d       = 1'b1;
    we_n_d        = 1'b1;
    reset_n_d     = !(next_state == S_IDLE || next_state == S_RST_HOLD);
    cke_d         = (next_state >= S_XPR);
    clk_disable_d = (next_state == S_IDLE);
    busy_d        = (next_state != S_IDLE) && (next_state != S_DONE);
    done_d        = (next_state == S_DONE);
    if (entering) begin
      unique case (next_state)
        S_MR2: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          bank_d    = BANK_WIDTH'(2);
          address_d = MR2;
        end
        S_MR3: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          bank_d    = BANK_WIDTH'(3);
          address_d = MR3;
        end
        S_MR1: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          bank_d    = BANK_WIDTH'(1);
          address_d = MR1;
        end
        S_MR0: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          bank_d    = BANK_WIDTH'(0);
          address_d = MR0;
        end
        S_ZQCL: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b110;
          address_d = ZQ_ADDR;
        end
        default: begin
          address_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      dfi_address          <= '0;
      dfi_bank             <= '0;
      dfi_ras_n            <= 1'b1;
      dfi_cas_n            <= 1'b1;
      dfi_we_n             <= 1'b1;
      dfi_cs_n             <= 1'b1;
      dfi_cke              <= 1'b0;
      dfi_odt              <= 1'b0;
      dfi_reset_n          <= 1'b0;
      dfi_dram_clk_disable <= 1'b1;
      busy                 <= 1'b0;
      init_done            <= 1'b0;
    end else begin
      state                <= next_state;
      cnt                  <= cnt_d;
      dfi_address          <= address_d;
      dfi_bank             <= bank_d;
      dfi_ras_n            <= ras_n_d;
      dfi_cas_n            <= cas_n_d;
      dfi_we_n             <= we_n_d;
      dfi_cs_n             <= !cke_d;
      dfi_cke              <= cke_d;
      dfi_odt              <= 1'b0;
      dfi_reset_n          <= reset_n_d;
      dfi_dram_clk_disable <= clk_disable_d;
      busy                 <= busy_d;
      init_done            <= done_d;
    end
  end

endmodule

// File: tb/tb_dfi_init_seq.sv
// Directed bench for dfi_init_seq: reset idle, full sequence timing, start re-pulses,
// mid-sequence async reset and a T_MRD=1 build run side by side.
module tb_dfi_init_seq;

  localparam int AW = 14;
  localparam int BW = 3;
  localparam int VW = 27;
  localparam logic [AW-1:0] V_MR0 = 14'h0520;
  localparam logic [AW-1:0] V_MR1 = 14'h0044;
  localparam logic [AW-1:0] V_MR2 = 14'h0008;
  localparam logic [AW-1:0] V_MR3 = 14'h0000;
  // {reset_n,cke,cs_n,ras_n,cas_n,we_n,odt,clk_disable,busy,init_done,bank,address}
  localparam logic [VW-1:0] RST_VEC = {1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 14'd0};

  logic clk;
  logic rst_n;
  logic start;

  logic [AW-1:0] a_address, b_address;
  logic [BW-1:0] a_bank, b_bank;
  logic a_ras_n, a_cas_n, a_we_n, a_cs_n, a_cke, a_odt, a_reset_n, a_clk_dis, a_busy, a_done;
  logic b_ras_n, b_cas_n, b_we_n, b_cs_n, b_cke, b_odt, b_reset_n, b_clk_dis, b_busy, b_done;
  logic [3:0] a_state, b_state;
  logic [VW-1:0] vec_a, vec_b;

  int n_cmp;
  int n_bad;
  logic [VW-1:0] exp_a_q[$];
  logic [VW-1:0] exp_b_q[$];

  assign vec_a = {a_reset_n, a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_odt, a_clk_dis, a_busy, a_done, a_bank, a_address};
  assign vec_b = {b_reset_n, b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_odt, b_clk_dis, b_busy, b_done, b_bank, b_address};

  dfi_init_seq #(
    .ADDR_WIDTH(AW), .BANK_WIDTH(BW), .CNT_W(20),
    .T_RESET(10), .T_CKE(20), .T_XPR(5), .T_MRD(4), .T_MOD(12), .T_ZQINIT(32),
    .MR0(V_MR0), .MR1(V_MR1), .MR2(V_MR2), .MR3(V_MR3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dfi_address(a_address), .dfi_bank(a_bank),
    .dfi_ras_n(a_ras_n), .dfi_cas_n(a_cas_n), .dfi_we_n(a_we_n),
    .dfi_cs_n(a_cs_n), .dfi_cke(a_cke), .dfi_odt(a_odt), .dfi_reset_n(a_reset_n),
    .dfi_dram_clk_disable(a_clk_dis), .busy(a_busy), .init_done(a_done),
    .dbg_state(a_state)
  );

  dfi_init_seq #(
    .ADDR_WIDTH(AW), .BANK_WIDTH(BW), .CNT_W(20),
    .T_RESET(10), .T_CKE(20), .T_XPR(5), .T_MRD(1), .T_MOD(12), .T_ZQINIT(32),
    .MR0(V_MR0), .MR1(V_MR1), .MR2(V_MR2), .MR3(V_MR3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dfi_address(b_address), .dfi_bank(b_bank),
    .dfi_ras_n(b_ras_n), .dfi_cas_n(b_cas_n), .dfi_we_n(b_we_n),
    .dfi_cs_n(b_cs_n), .dfi_cke(b_cke), .dfi_odt(b_odt), .dfi_reset_n(b_reset_n),
    .dfi_dram_clk_disable(b_clk_dis), .busy(b_busy), .init_done(b_done),
    .dbg_state(b_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected output vector k cycles after the start-sampling edge, from the timing table.
  function automatic logic [VW-1:0] exp_vec(input int k, input int mrd);
    logic rn, ck, ras, cas, we, dn;
    logic [BW-1:0] bk;
    logic [AW-1:0] ad;
    int m, zq;
    m  = 35;
    zq = m + 3 * mrd + 12;
    rn = (k >= 10);
    ck = (k >= 30);
    dn = (k >= zq + 32);
    {ras, cas, we} = 3'b111;
    bk = '0;
    ad = '0;
    if (k == m)                begin {ras, cas, we} = 3'b000; bk = 3'd2; ad = V_MR2; end
    else if (k == m + mrd)     begin {ras, cas, we} = 3'b000; bk = 3'd3; ad = V_MR3; end
    else if (k == m + 2 * mrd) begin {ras, cas, we} = 3'b000; bk = 3'd1; ad = V_MR1; end
    else if (k == m + 3 * mrd) begin {ras, cas, we} = 3'b000; bk = 3'd0; ad = V_MR0; end
    else if (k == zq)          begin {ras, cas, we} = 3'b110; ad = 14'h0400; end
    return {rn, ck, !ck, ras, cas, we, 1'b0, 1'b0, !dn, dn, bk, ad};
  endfunction

  // Driver tasks
  task automatic check_reset_vec(input string tag);
    check({tag, "_a"}, 32'(vec_a), 32'(RST_VEC));
    check({tag, "_b"}, 32'(vec_b), 32'(RST_VEC));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vec("in_reset");
    rst_n = 1'b1;
  endtask

  // Called #1 after an edge; the following edge becomes E0.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Steps through the sequence starting #1 after E0. repulse drives start again mid-run;
  // rst_at >= 0 asserts rst_n in that cycle and returns.
  task automatic run_seq(input int ncyc, input bit repulse, input int rst_at);
    logic [VW-1:0] ea, eb;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      exp_a_q.push_back(exp_vec(k, 4));
      exp_b_q.push_back(exp_vec(k, 1));
    end
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      check($sformatf("seq_a k=%0d", k), 32'(vec_a), 32'(ea));
      check($sformatf("seq_b k=%0d", k), 32'(vec_b), 32'(eb));
      if (repulse) start = (k == 14 || k == 49 || k == 119);
      if (k == rst_at) begin
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vec("async_rst");
        return;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vec("por");
    check("por_state", 32'(a_state), 32'd0);
    rst_n = 1'b1;

    // Idle after reset: nothing moves without start.
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      check_reset_vec($sformatf("idle%0d", i));
    end

    // Plain sequence, both the T_MRD=4 and T_MRD=1 builds.
    pulse_start();
    run_seq(130, 1'b0, -1);
    check("done_state_nonidle", 32'(a_state != 4'd0), 32'd1);

    // start re-pulsed while running must not restart anything.
    @(posedge clk);
    #1;
    do_reset();
    @(posedge clk);
    #1;
    pulse_start();
    run_seq(130, 1'b1, -1);

    // Async reset between MR3 and MR1, release at 45, start again at 50.
    do_reset();
    @(posedge clk);
    #1;
    pulse_start();
    run_seq(130, 1'b0, 41);
    for (int e = 42; e <= 49; e++) begin
      @(posedge clk);
      #1;
      check_reset_vec($sformatf("held_rst e=%0d", e));
      if (e == 45) rst_n = 1'b1;
      if (e == 49) start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    run_seq(100, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
